ntt_job_scheduler: RTL and testbench

- Round-robin scheduler that shares one NTT/INTT core among NUM_REQ requesters, e.g. keygen, encaps, decaps, and the polynomial-vector loop over k.
- Arbitrates level requests and launches the core with a one-cycle start.
- Holds is_ntt and the polynomial slot stable for the whole job, waits for the core's done_compute pulse, then returns a completion pulse to the owning requester.
- Sits between the KEM control FSMs and the NTT top-level.

---
 rtl/ntt_job_scheduler_if.sv | 26 ++
 rtl/ntt_job_scheduler.sv | 140 ++++++++++++++
 tb/tb_ntt_job_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_job_scheduler_if.sv
// Requester/core handshake bundle for the NTT job scheduler.
// The slave side is the scheduler; the master side drives requests and core_done.
interface ntt_job_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_POLY = 3
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_is_ntt;
  logic [NUM_REQ*WIDTH_POLY-1:0] req_poly;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done_req;
  logic                          core_start;
  logic                          core_is_ntt;
  logic [WIDTH_POLY-1:0]         core_poly;
  logic                          core_done;

  modport slave (
    input  req, req_is_ntt, req_poly, core_done,
    output gnt, done_req, core_start, core_is_ntt, core_poly
  );

  modport master (
    output req, req_is_ntt, req_poly, core_done,
    input  gnt, done_req, core_start, core_is_ntt, core_poly
  );
endinterface

// File: rtl/ntt_job_scheduler.sv
// Round-robin scheduler sharing one NTT/INTT core among NUM_REQ requesters.
// Define NTT_SCHED_WATCHDOG_EN to add a WAIT-state watchdog with a sticky err flag.
module ntt_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH_POLY     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ntt_job_scheduler_if.slave         bus,
  input  logic                       i_err_clr,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_owner,
  output logic [15:0]                o_jobs_done,
  output logic                       o_err
);
  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RELEASE} state_t;

  state_t                  r_state;
  logic [OW-1:0]           r_owner;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [NUM_REQ-1:0]      r_done_req;
  logic                    r_core_start;
  logic                    r_core_is_ntt;
  logic [WIDTH_POLY-1:0]   r_core_poly;
  logic                    r_busy;
  logic [15:0]             r_jobs_done;

  logic                    w_any;
  logic [OW-1:0]           w_sel;
  logic                    w_is_ntt;
  logic [WIDTH_POLY-1:0]   w_poly;

  // Scan distances from farthest to nearest so the requester right after
  // the last owner overwrites any lower-priority pick.
  always_comb begin
    w_any    = 1'b0;
    w_sel    = r_owner;
    w_is_ntt = 1'b0;
    w_poly   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == (int'(r_owner) + k) % NUM_REQ && bus.req[i]) begin
          w_any    = 1'b1;
          w_sel    = OW'(i);
          w_is_ntt = bus.req_is_ntt[i];
          w_poly   = bus.req_poly[i*WIDTH_POLY +: WIDTH_POLY];
        end
      end
    end
  end

`ifdef NTT_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] r_wd_cnt;
  logic           r_err;
  assign o_err = r_err;
`else
  logic w_unused;
  assign w_unused = i_err_clr | (TIMEOUT_CYCLES == 0);
  assign o_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_owner       <= OW'(NUM_REQ - 1);
      r_gnt         <= '0;
      r_done_req    <= '0;
      r_core_start  <= 1'b0;
      r_core_is_ntt <= 1'b0;
      r_core_poly   <= '0;
      r_busy        <= 1'b0;
      r_jobs_done   <= '0;
`ifdef NTT_SCHED_WATCHDOG_EN
      r_wd_cnt      <= '0;
      r_err         <= 1'b0;
`endif
    end else begin
      r_gnt        <= '0;
      r_done_req   <= '0;
      r_core_start <= 1'b0;
`ifdef NTT_SCHED_WATCHDOG_EN
      // A timeout later in this block overrides the clear.
      if (i_err_clr) r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state        <= S_LAUNCH;
            r_owner        <= w_sel;
            r_gnt[w_sel]   <= 1'b1;
            r_core_start   <= 1'b1;
            r_core_is_ntt  <= w_is_ntt;
            r_core_poly    <= w_poly;
            r_busy         <= 1'b1;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
`ifdef NTT_SCHED_WATCHDOG_EN
          r_wd_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.core_done) begin
            r_state             <= S_RELEASE;
            r_done_req[r_owner] <= 1'b1;
            r_jobs_done         <= r_jobs_done + 16'd1;
          end
`ifdef NTT_SCHED_WATCHDOG_EN
          else if (r_wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) begin
            r_state             <= S_RELEASE;
            r_done_req[r_owner] <= 1'b1;
            r_err               <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.done_req    = r_done_req;
  assign bus.core_start  = r_core_start;
  assign bus.core_is_ntt = r_core_is_ntt;
  assign bus.core_poly   = r_core_poly;
  assign o_busy          = r_busy;
  assign o_owner         = r_owner;
  assign o_jobs_done     = r_jobs_done;
endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Directed bench for ntt_job_scheduler: single job, round robin, mode/slot
// isolation, spurious done, mid-job reset and (when enabled) the watchdog.
module tb_ntt_job_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic        err;
  logic [1:0]  owner;
  logic [15:0] jobs;
  int          n_pass = 0;
  int          n_checks = 0;
  int          w;

  always #5 clk = ~clk;

  ntt_job_scheduler_if #(.NUM_REQ(4), .WIDTH_POLY(3)) bus ();

  ntt_job_scheduler #(.NUM_REQ(4), .WIDTH_POLY(3), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .i_err_clr  (err_clr),
    .o_busy     (busy),
    .o_owner    (owner),
    .o_jobs_done(jobs),
    .o_err      (err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_gnt"},   bus.gnt, 0);
    chk({tag, "_done"},  bus.done_req, 0);
    chk({tag, "_start"}, bus.core_start, 0);
    chk({tag, "_ntt"},   bus.core_is_ntt, 0);
    chk({tag, "_poly"},  bus.core_poly, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_owner"}, owner, 3);
    chk({tag, "_jobs"},  jobs, 0);
    chk({tag, "_err"},   err, 0);
  endtask

  // Waits (bounded) for core_start, checks the launch, answers core_done
  // dly cycles after the start cycle and checks the completion pulse.
  task automatic serve(input logic [3:0] eg, input int dly, input logic [2:0] ep,
                       input logic en, output int waited);
    waited = 0;
    while (bus.core_start !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("start", bus.core_start, 1);
    chk("gnt", bus.gnt, eg);
    chk("launch_poly", bus.core_poly, ep);
    chk("launch_ntt", bus.core_is_ntt, en);
    chk("busy", busy, 1);
    tick();
    chk("gnt_pulse", bus.gnt, 0);
    chk("start_pulse", bus.core_start, 0);
    repeat (dly - 1) tick();
    chk("held_poly", bus.core_poly, ep);
    chk("held_ntt", bus.core_is_ntt, en);
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    chk("done_req", bus.done_req, eg);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.req = '0; bus.req_is_ntt = '0; bus.req_poly = '0; bus.core_done = 1'b0;
    tick(); tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single job: start at cycle 1, core_done at cycle 50, done_req at 51.
    bus.req = 4'b0001; bus.req_is_ntt = 4'b0001; bus.req_poly = 12'h003;
    serve(4'b0001, 49, 3'd3, 1'b1, w);
    chk("t1_latency", w, 1);
    chk("t1_jobs", jobs, 1);
    bus.req = '0;
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", bus.done_req, 0);
    chk("t1_poly_kept", bus.core_poly, 3);
    chk("t1_owner", owner, 0);

    // Round robin from a fresh reset with all requesters held.
    rst_n = 1'b0;
    tick();
    check_reset("rst2");
    rst_n = 1'b1;
    tick();
    bus.req = 4'b1111; bus.req_is_ntt = 4'b0101;
    bus.req_poly = {3'd7, 3'd6, 3'd5, 3'd4};
    serve(4'b0001, 40, 3'd4, 1'b1, w); chk("rr0_wait", w, 1);
    serve(4'b0010, 40, 3'd5, 1'b0, w); chk("rr1_wait", w, 2);
    serve(4'b0100, 40, 3'd6, 1'b1, w); chk("rr2_wait", w, 2);
    serve(4'b1000, 40, 3'd7, 1'b0, w); chk("rr3_wait", w, 2);
    chk("rr_jobs4", jobs, 4);
    serve(4'b0001, 40, 3'd4, 1'b1, w); chk("rr4_wait", w, 2);
    bus.req = '0;
    chk("rr_jobs5", jobs, 5);
    tick();

    // Mode/slot isolation: requester 2 arrives while requester 1 is in WAIT.
    bus.req = 4'b0010; bus.req_is_ntt = 4'b0010;
    bus.req_poly = {3'd0, 3'd5, 3'd1, 3'd0};
    tick();
    chk("iso_gnt1", bus.gnt, 4'b0010);
    chk("iso_ntt1", bus.core_is_ntt, 1);
    chk("iso_poly1", bus.core_poly, 1);
    bus.req = 4'b0100;
    repeat (5) tick();
    chk("iso_wait_ntt", bus.core_is_ntt, 1);
    chk("iso_wait_poly", bus.core_poly, 1);
    chk("iso_wait_gnt", bus.gnt, 0);
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    chk("iso_rel_done", bus.done_req, 4'b0010);
    chk("iso_rel_ntt", bus.core_is_ntt, 1);
    chk("iso_rel_poly", bus.core_poly, 1);
    serve(4'b0100, 10, 3'd5, 1'b0, w);
    chk("iso_wait2", w, 2);
    bus.req = '0;
    chk("iso_jobs", jobs, 7);
    tick();

    // Spurious core_done in IDLE and in LAUNCH.
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    chk("sp_idle_busy", busy, 0);
    chk("sp_idle_done", bus.done_req, 0);
    chk("sp_idle_start", bus.core_start, 0);
    tick();
    chk("sp_idle_done2", bus.done_req, 0);
    bus.req = 4'b0001; bus.req_is_ntt = 4'b0001; bus.req_poly = 12'h002;
    tick();
    chk("sp_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    chk("sp_launch_done", bus.done_req, 0);
    chk("sp_launch_busy", busy, 1);
    tick(); tick();
    chk("sp_wait_done", bus.done_req, 0);
    chk("sp_wait_busy", busy, 1);
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    chk("sp_real_done", bus.done_req, 4'b0001);
    chk("sp_jobs", jobs, 8);
    tick();

    // Reset in the middle of WAIT.
    bus.req = 4'b0010;
    tick();
    chk("mr_gnt", bus.gnt, 4'b0010);
    bus.req = '0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check_reset("mr_rst");
    tick();
    chk("mr_rst_done", bus.done_req, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("mr_after_done", bus.done_req, 0);
    chk("mr_after_busy", busy, 0);
    bus.req = 4'b0010; bus.req_is_ntt = 4'b0010; bus.req_poly = 12'h030;
    serve(4'b0010, 5, 3'd6, 1'b1, w);
    chk("mr_wait", w, 1);
    bus.req = '0;
    chk("mr_jobs", jobs, 1);
    tick();

`ifdef NTT_SCHED_WATCHDOG_EN
    // Watchdog: no core_done; timeout after 16 WAIT cycles, err_clr loses.
    bus.req = 4'b0001; bus.req_is_ntt = 4'b0001; bus.req_poly = 12'h004;
    tick();
    chk("wd_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    repeat (16) tick();
    chk("wd_pre_done", bus.done_req, 0);
    chk("wd_pre_err", err, 0);
    chk("wd_pre_busy", busy, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_done", bus.done_req, 4'b0001);
    chk("wd_err", err, 1);
    chk("wd_jobs", jobs, 1);
    tick();
    chk("wd_sticky", err, 1);
    chk("wd_idle", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_clr", err, 0);
`else
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_tied", err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
